// File: rtl/sc_io_pkg.sv
// Shared constants and address decode for the single-cycle computer I/O window.
// Latency: n/a (package). Backpressure: n/a.
// Register layout: OUT ports at 0x00, IN ports at 0x40, STATUS at 0x80, MASK at 0x84.
package sc_io_pkg;

    localparam logic [7:0] OUT_OFS    = 8'h00;
    localparam logic [7:0] IN_OFS     = 8'h40;
    localparam logic [7:0] STATUS_OFS = 8'h80;
    localparam logic [7:0] MASK_OFS   = 8'h84;
    localparam int         MAX_PORTS  = 16;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_OUT,
        SEL_IN,
        SEL_STATUS,
        SEL_MASK
    } io_reg_e;

    function automatic logic [3:0] port_idx(input logic [7:0] ofs);
        return ofs[5:2];
    endfunction

    // Port indices past the configured count decode as SEL_NONE, so they read 0 and drop writes.
    function automatic io_reg_e decode_ofs(input logic [7:0] ofs, input int n_out, input int n_in);
        int idx;
        idx = int'(port_idx(ofs));
        decode_ofs = SEL_NONE;
        if (ofs[7:6] == OUT_OFS[7:6] && idx < n_out && idx < MAX_PORTS) begin
            decode_ofs = SEL_OUT;
        end else if (ofs[7:6] == IN_OFS[7:6] && idx < n_in && idx < MAX_PORTS) begin
            decode_ofs = SEL_IN;
        end else if (ofs[7:2] == STATUS_OFS[7:2]) begin
            decode_ofs = SEL_STATUS;
        end else if (ofs[7:2] == MASK_OFS[7:2]) begin
            decode_ofs = SEL_MASK;
        end
    endfunction

endpackage

// File: rtl/sc_io_ports_if.sv
// CPU data bus and data-memory side of the I/O controller.
// Latency: all signals combinational. Backpressure: none, single-cycle bus.
interface sc_io_ports_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wmem;
    logic [31:0] mem_rdata;
    logic [31:0] cpu_rdata;
    logic        dmem_we;
    logic        io_sel;

    modport master (
        output addr, wdata, wmem, mem_rdata,
        input  cpu_rdata, dmem_we, io_sel
    );

    modport slave (
        input  addr, wdata, wmem, mem_rdata,
        output cpu_rdata, dmem_we, io_sel
    );
endinterface

// File: rtl/sc_io_sync.sv
// Two-flop input synchroniser plus previous-value stage for change detection (SC_IO_IRQ_EN).
// Latency: dout valid 2 edges after din; chg high during the cycle after dout changes.
// Backpressure: none.
module sc_io_sync #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic [W-1:0] din,
`ifdef SC_IO_IRQ_EN
    output logic         chg,
`endif
    output logic [W-1:0] dout
);

    logic [W-1:0] s1_q, s1_d;
    logic [W-1:0] s2_q, s2_d;

    always_comb begin
        s1_d = din;
        s2_d = s1_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign dout = s2_q;

`ifdef SC_IO_IRQ_EN
    logic [W-1:0] s3_q, s3_d;

    always_comb begin
        s3_d = s2_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s3_q <= '0;
        end else begin
            s3_q <= s3_d;
        end
    end

    assign chg = (s2_q != s3_q);
`endif

endmodule

// File: rtl/sc_io_ports.sv
// Memory-mapped I/O window: registered outputs, synchronised inputs, change flags + irq (SC_IO_IRQ_EN).
// Latency: reads combinational, writes land 1 edge after the store. Backpressure: none.
// Stores that hit the window are steered away from data memory.
module sc_io_ports
    import sc_io_pkg::*;
#(
    parameter int          NUM_OUT   = 2,
    parameter int          NUM_IN    = 2,
    parameter int          DATA_W    = 32,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
    input  logic                     clock,
    input  logic                     resetn,
    sc_io_ports_if.slave             bus,
    input  logic [NUM_IN*DATA_W-1:0] in_port,
    output logic [NUM_OUT*DATA_W-1:0] out_port,
    output logic                     irq
);

    io_reg_e     sel;
    logic [3:0]  idx;
    logic        io_wr;
    logic [31:0] io_rdata;
    logic        unused_bits;

    assign bus.io_sel  = (bus.addr[31:8] == BASE_ADDR[31:8]);
    assign bus.dmem_we = bus.wmem & ~bus.io_sel;
    assign io_wr       = bus.wmem & bus.io_sel;
    assign sel         = decode_ofs(bus.addr[7:0], NUM_OUT, NUM_IN);
    assign idx         = port_idx(bus.addr[7:0]);
    assign unused_bits = ^{bus.addr[1:0], bus.wdata};

    // Input synchronisers
    logic [DATA_W-1:0] in_sync [NUM_IN];
`ifdef SC_IO_IRQ_EN
    logic [NUM_IN-1:0] in_chg;
`endif

    for (genvar k = 0; k < NUM_IN; k++) begin : g_in
        sc_io_sync #(.W(DATA_W)) u_sync (
            .clock  (clock),
            .resetn (resetn),
            .din    (in_port[k*DATA_W +: DATA_W]),
`ifdef SC_IO_IRQ_EN
            .chg    (in_chg[k]),
`endif
            .dout   (in_sync[k])
        );
    end

    // Output registers
    logic [DATA_W-1:0] out_q [NUM_OUT];
    logic [DATA_W-1:0] out_d [NUM_OUT];

    always_comb begin
        for (int k = 0; k < NUM_OUT; k++) begin
            out_d[k] = out_q[k];
            if (io_wr && sel == SEL_OUT && idx == 4'(k)) begin
                out_d[k] = bus.wdata[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                out_q[k] <= '0;
            end
        end else begin
            out_q <= out_d;
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
        assign out_port[k*DATA_W +: DATA_W] = out_q[k];
    end

`ifdef SC_IO_IRQ_EN
    logic [NUM_IN-1:0] flag_q, flag_d;
    logic [NUM_IN-1:0] mask_q, mask_d;

    // OR-ing the change pulses in after the W1C clear makes a same-cycle set win.
    always_comb begin
        flag_d = flag_q;
        mask_d = mask_q;
        if (io_wr && sel == SEL_STATUS) begin
            flag_d = flag_q & ~bus.wdata[NUM_IN-1:0];
        end
        if (io_wr && sel == SEL_MASK) begin
            mask_d = bus.wdata[NUM_IN-1:0];
        end
        flag_d = flag_d | in_chg;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            flag_q <= '0;
            mask_q <= '0;
        end else begin
            flag_q <= flag_d;
            mask_q <= mask_d;
        end
    end

    assign irq = |(flag_q & mask_q);
`else
    assign irq = 1'b0;
`endif

    // Read mux
    always_comb begin
        io_rdata = '0;
        case (sel)
            SEL_OUT: begin
                for (int k = 0; k < NUM_OUT; k++) begin
                    if (idx == 4'(k)) io_rdata = 32'(out_q[k]);
                end
            end
            SEL_IN: begin
                for (int k = 0; k < NUM_IN; k++) begin
                    if (idx == 4'(k)) io_rdata = 32'(in_sync[k]);
                end
            end
`ifdef SC_IO_IRQ_EN
            SEL_STATUS: io_rdata = 32'(flag_q);
            SEL_MASK:   io_rdata = 32'(mask_q);
`endif
            default: io_rdata = '0;
        endcase
    end

    assign bus.cpu_rdata = bus.io_sel ? io_rdata : bus.mem_rdata;

endmodule
